pipe_stage_chain: RTL and testbench

//  Parametrised successor to the fixed 5-stage IF/ID/EX/MEM/WB register set: a chain of DEPTH

---
 rtl/pipe_stage_chain_if.sv | 13 +
 rtl/pipe_stage_chain.sv | 132 +++++++++++++
 tb/tb_pipe_stage_chain.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Purpose: valid/ready payload link used on both sides of pipe_stage_chain.
//   master drives valid/data and samples ready; slave the reverse.
// Ports: valid (item present), data (WIDTH-bit payload), ready (sink accepts).
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_chain.sv
// Purpose: DEPTH-stage valid/ready register chain with per-stage flush, bubble collapse,
//   occupancy count and optional stall/flush statistics (macro PIPE_STATS_EN).
// Latency: DEPTH-1 edges from input accept to output when never stalled.
// Backpressure: only stages behind a held, occupied stage stall; bubbles ahead are filled.
// Ports: clk_i/reset_i (sync, active-high); in_if (slave: producer side);
//   out_if (master: consumer side); flush_i[i] kills stages 0..i; stage_valid_o per-stage
//   valid; count_o occupancy; stall_cnt_o/flush_cnt_o statistics (0 without PIPE_STATS_EN).
module pipe_stage_chain #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  pipe_stage_chain_if.slave   in_if,
  pipe_stage_chain_if.master  out_if,
  input  logic [DEPTH-1:0]    flush_i,
  output logic [DEPTH-1:0]    stage_valid_o,
  output logic [CNT_W-1:0]    count_o,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] rdy;       // stage k can take a new item this cycle
  logic [DEPTH-1:0] kill_src;  // stage k is at or below the highest flush index
  logic             any_flush;
  logic             in_fire;
  logic             all_v;
  logic             any_f;

  // rdy[k] = out_ready | some stage k..DEPTH-1 is empty; kill_src[k] = |flush_i[DEPTH-1:k].
  // Built as suffix reductions so there is no combinational chain through rdy itself.
  always_comb begin
    all_v    = 1'b1;
    any_f    = 1'b0;
    rdy      = '0;
    kill_src = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      all_v       = all_v & v_q[k];
      any_f       = any_f | flush_i[k];
      rdy[k]      = out_if.ready | ~all_v;
      kill_src[k] = any_f;
    end
  end

  assign any_flush = kill_src[0];
  assign in_fire   = in_if.valid & rdy[0];

  // A ready stage loads from its source (possibly a bubble); a held stage keeps its item.
  // Items whose source stage is flushed land invalid wherever they end up.
  always_comb begin
    v_d = '0;
    for (int k = 0; k < DEPTH; k++) d_d[k] = d_q[k];

    if (rdy[0]) begin
      v_d[0] = in_fire & ~any_flush;
      if (in_fire) d_d[0] = in_if.data;
    end else begin
      v_d[0] = v_q[0] & ~kill_src[0];
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (rdy[k]) begin
        v_d[k] = v_q[k-1] & ~kill_src[k-1];
        if (v_q[k-1]) d_d[k] = d_q[k-1];
      end else begin
        v_d[k] = v_q[k] & ~kill_src[k];
      end
    end

    count_d = '0;
    for (int k = 0; k < DEPTH; k++) count_d = count_d + CNT_W'(v_d[k]);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
    end
  end

  assign in_if.ready   = rdy[0];
  // A head being flushed is never offered to the consumer.
  assign out_if.valid  = v_q[DEPTH-1] & ~flush_i[DEPTH-1];
  assign out_if.data   = d_q[DEPTH-1];
  assign stage_valid_o = v_q;
  assign count_o       = count_q;

`ifdef PIPE_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic [31:0] kill_n;
  logic [32:0] flush_sum;

  // Each killed item is counted once, by the stage it occupied, plus a discarded input.
  always_comb begin
    kill_n = 32'(in_fire & any_flush);
    for (int k = 0; k < DEPTH; k++) kill_n = kill_n + 32'(v_q[k] & kill_src[k]);
    flush_sum = {1'b0, flush_q} + {1'b0, kill_n};
    flush_d   = flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    stall_d   = stall_q;
    if (out_if.valid && !out_if.ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Purpose: self-checking bench for pipe_stage_chain (WIDTH=32, DEPTH=5).
// Latency: expected items are queued at accept time and checked when popped at the output.
// Backpressure: out_ready is driven per scenario; the monitor only pops on valid & ready.
module tb_pipe_stage_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;

  typedef struct {
    logic [31:0] dat;
    int          acc;
    bit          lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] stage_valid;
  logic [2:0]       count;
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;

  pipe_stage_chain_if #(.WIDTH(WIDTH)) in_if ();
  pipe_stage_chain_if #(.WIDTH(WIDTH)) out_if ();

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .in_if         (in_if),
    .out_if        (out_if),
    .flush_i       (flush),
    .stage_valid_o (stage_valid),
    .count_o       (count),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   peak   = 0;
  exp_t sb[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the consumer takes an item.
  always @(negedge clk) begin
    if (!reset && out_if.valid && out_if.ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got %0h expected none", out_if.data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_if.data, e.dat);
        // accept seen at cycle c, output visible after DEPTH-1 more edges -> delta DEPTH
        if (e.lat) chk("latency", cyc - e.acc, DEPTH);
      end
    end
    if (int'(count) > peak) peak = int'(count);
  end

  // Present one item until accepted; optionally queue its expectation.
  task automatic send(input logic [31:0] val, input bit expd, input bit lat, input bit chk_rdy);
    int n;
    n = 0;
    in_if.valid = 1'b1;
    in_if.data  = val;
    forever begin
      @(negedge clk);
      if (chk_rdy && n == 0) chk("in_ready_stream", in_if.ready, 1);
      if (in_if.ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    if (in_if.ready && expd) sb.push_back('{val, cyc, lat});
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] s0;
    reset        = 1'b1;
    flush        = '0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_out_data", out_if.data, 0);
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_if.ready, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);

    // Back-to-back stream with a free consumer.
    idle(1);
    out_if.ready = 1'b1;
    peak = 0;
    for (int i = 1; i <= 8; i++) send(32'(i), 1'b1, 1'b1, 1'b1);
    idle(8);
    @(negedge clk);
    chk("stream_peak_count", peak, 5);
    chk("stream_sb_empty", sb.size(), 0);

    // Fill under backpressure, then release with the 6th item pending.
    idle(1);
    out_if.ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(32'(i), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", count, 5);
    chk("full_in_ready", in_if.ready, 0);
    idle(1);
    out_if.ready = 1'b1;
    fork
      send(32'h6, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("drain_no_gap", out_if.valid, 1);
      end
    join
    idle(6);
    chk("drain_sb_empty", sb.size(), 0);

    // Bubble collapse: A then B two idle cycles later, consumer stalled.
    out_if.ready = 1'b0;
    send(32'hA, 1'b1, 1'b0, 1'b0);
    idle(2);
    send(32'hB, 1'b1, 1'b0, 1'b0);
    idle(6);
    @(negedge clk);
    chk("collapse_stage_valid", stage_valid, 5'b11000);
    chk("collapse_count", count, 2);
    idle(1);
    out_if.ready = 1'b1;
    idle(4);
    chk("collapse_sb_empty", sb.size(), 0);

    // Flush stages 0..2 of a full chain while a new input is offered.
    out_if.ready = 1'b0;
    send(32'h10, 1'b1, 1'b0, 1'b0);
    send(32'h11, 1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) send(32'h10 + 32'(i), 1'b0, 1'b0, 1'b0);
    flush       = 5'b00100;
    in_if.valid = 1'b1;
    in_if.data  = 32'h15;
    @(negedge clk);
    chk("flush_in_ready", in_if.ready, 0);
    @(posedge clk);
    #1;
    flush       = '0;
    in_if.valid = 1'b0;
    @(negedge clk);
    chk("flush_stage_valid", stage_valid, 5'b11000);
    chk("flush_count", count, 2);
    idle(1);
    out_if.ready = 1'b1;
    idle(4);
    chk("flush_sb_empty", sb.size(), 0);

    // Input accepted under flush is discarded; in_ready unaffected.
    flush       = 5'b00001;
    in_if.valid = 1'b1;
    in_if.data  = 32'h99;
    @(negedge clk);
    chk("flush_in_in_ready", in_if.ready, 1);
    @(posedge clk);
    #1;
    flush       = '0;
    in_if.valid = 1'b0;
    @(negedge clk);
    chk("flush_in_count", count, 0);
    chk("flush_in_stage_valid", stage_valid, 0);
    idle(6);

    // Reset mid-stream with a full chain.
    out_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h20 + 32'(i), 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_if.valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_stage_valid", stage_valid, 0);
    chk("midrst_in_ready", in_if.ready, 1);
    idle(1);
    out_if.ready = 1'b1;
    send(32'h77, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("midrst_sb_empty", sb.size(), 0);

    // Statistics: stall cycles and killed items.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    out_if.ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(32'h30 + 32'(i), 1'b0, 1'b0, 1'b0);
    idle(6);
    @(negedge clk);
    s0 = stall_cnt;
    idle(3);
    @(negedge clk);
`ifdef PIPE_STATS_EN
    chk("stall_cnt_delta", stall_cnt, s0 + 32'd3);
`else
    chk("stall_cnt_zero", stall_cnt, 0);
`endif
    idle(1);
    flush = 5'b11111;
    @(negedge clk);
    chk("flushed_head_masked", out_if.valid, 0);
    @(posedge clk);
    #1;
    flush = '0;
    @(negedge clk);
    chk("stats_count", count, 0);
`ifdef PIPE_STATS_EN
    chk("flush_cnt", flush_cnt, 3);
`else
    chk("flush_cnt_zero", flush_cnt, 0);
`endif
    idle(2);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
